// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle datapath: sequencer states, ALU and
// branch operation codes, the HALT opcode and instruction field positions.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } mc_state_e;

  // ALU operation codes driven on alu_control
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;
  localparam logic [3:0] ALU_SLT = 4'd9;

  // Branch operation codes driven on brOp (any code with bit 2 set is a register-relative jump)
  localparam logic [2:0] BR_NONE   = 3'b000;
  localparam logic [2:0] BR_ALWAYS = 3'b001;
  localparam logic [2:0] BR_A_ZERO = 3'b010;
  localparam logic [2:0] BR_A_NEG  = 3'b011;
  localparam logic [2:0] BR_JREG   = 3'b100;

  localparam logic [5:0] OP_HALT = 6'h3F;

  // Instruction field positions
  localparam int OPC_LSB = 26;
  localparam int RS_LSB  = 22;
  localparam int RT_LSB  = 18;
  localparam int RD_LSB  = 14;

  // Operand A is the register value for plain ALU instructions and register-relative
  // jumps; PC-relative branches add their offset to PC+1 instead.
  function automatic logic op_a_from_reg(input logic [2:0] br_op);
    return (br_op == BR_NONE) || br_op[2];
  endfunction

  // Branch decision, evaluated in WB from the A latch
  function automatic logic branch_taken(input logic [2:0] br_op, input logic a_zero,
                                        input logic a_neg);
    logic taken;
    casez (br_op)
      3'b1??:    taken = 1'b1;
      BR_ALWAYS: taken = 1'b1;
      BR_A_ZERO: taken = a_zero;
      BR_A_NEG:  taken = a_neg;
      default:   taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU with zero/negative/signed-overflow flags. All arithmetic
// wraps modulo 2^DATA_W; shift amounts come from op_b[5:0].
module mc_alu
  import mc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              negative,
  output logic              overflow
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [5:0]        shamt;

  assign sum   = op_a + op_b;
  assign diff  = op_a - op_b;
  assign shamt = op_b[5:0];

  // Operation select; overflow is only meaningful for ADD and SUB
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alu_control)
      ALU_ADD: begin
        result   = sum;
        overflow = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum[DATA_W-1] != op_a[DATA_W-1]);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (diff[DATA_W-1] != op_a[DATA_W-1]);
      end
      ALU_AND: result = op_a & op_b;
      ALU_OR:  result = op_a | op_b;
      ALU_XOR: result = op_a ^ op_b;
      ALU_NOR: result = ~(op_a | op_b);
      ALU_SLL: result = op_a << shamt;
      ALU_SRL: result = op_a >> shamt;
      ALU_SRA: result = DATA_W'($signed(op_a) >>> shamt);
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: result = '0;
    endcase
  end

  assign zero     = (result == '0);
  assign negative = result[DATA_W-1];

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle datapath: FETCH/DECODE/EXEC/MEM/WB sequencer, architectural
// latches (PC, IR, A, B, ALUOut, MDR), register file and req/ack memory ports.
// Control inputs come from an external decoder and are sampled DECODE..WB.
// Handshake: a request is held with stable address/data until the matching ack
// arrives (ack may come in the same cycle as the request); an ack seen while the
// request is low is ignored.
module multicycle_datapath
  import mc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              updPc,
  input  logic              reg_dst,
  input  logic              wr_reg,
  input  logic [3:0]        alu_control,
  input  logic              alu_src,
  input  logic              immSel,
  input  logic              rdMem,
  input  logic              wrMem,
  input  logic              mToReg,
  input  logic [2:0]        brOp,
  input  logic [3:0]        resultRegInp,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [31:0]       ins,
  output logic [DATA_W-1:0] result_out,
  output logic [DATA_W-1:0] rsOut_out,
  output logic [DATA_W-1:0] resultRegOut,
  output logic              zero,
  output logic              negative,
  output logic              overflow_flag,
  output logic              instr_done,
  output logic              halted,
  output mc_state_e         state_dbg
);

  mc_state_e         state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] aluout_q, aluout_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;
  logic              ovf_q, ovf_d;
  logic              instr_done_q, instr_done_d;
  logic              halted_q, halted_d;
  logic [DATA_W-1:0] regs_q [16];
  logic [DATA_W-1:0] regs_d [16];

  logic [3:0]        rs_idx, rt_idx, rd_idx, dest_idx;
  logic [DATA_W-1:0] rs_val, rt_val, dbg_val;
  logic [DATA_W-1:0] imm_ext, pc_plus1, op_a, op_b, wb_data;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero, alu_neg, alu_ovf;
  logic              taken;

  // Registers at or above NREGS do not exist: they read as zero and ignore writes
  function automatic logic reg_impl(input logic [3:0] idx);
    return 32'(idx) < NREGS;
  endfunction

  assign rs_idx   = ir_q[RS_LSB +: 4];
  assign rt_idx   = ir_q[RT_LSB +: 4];
  assign rd_idx   = ir_q[RD_LSB +: 4];
  assign dest_idx = reg_dst ? rd_idx : rt_idx;

  assign rs_val  = reg_impl(rs_idx) ? regs_q[rs_idx] : '0;
  assign rt_val  = reg_impl(rt_idx) ? regs_q[rt_idx] : '0;
  assign dbg_val = reg_impl(resultRegInp) ? regs_q[resultRegInp] : '0;

  // Jump offsets use the wide field, ordinary immediates the narrow one; both sign-extend
  assign imm_ext  = immSel ? DATA_W'($signed(ir_q[21:0])) : DATA_W'($signed(ir_q[13:0]));
  assign pc_plus1 = pc_q + DATA_W'(1);
  assign op_a     = op_a_from_reg(brOp) ? a_q : pc_plus1;
  assign op_b     = alu_src ? b_q : imm_ext;
  assign wb_data  = mToReg ? mdr_q : aluout_q;
  assign taken    = branch_taken(brOp, (a_q == '0), a_q[DATA_W-1]);

  mc_alu #(.DATA_W(DATA_W)) u_alu (
    .alu_control (alu_control),
    .op_a        (op_a),
    .op_b        (op_b),
    .result      (alu_result),
    .zero        (alu_zero),
    .negative    (alu_neg),
    .overflow    (alu_ovf)
  );

  // Sequencer and latch updates: one phase per cycle, memory phases wait for their ack
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    a_d          = a_q;
    b_d          = b_q;
    aluout_d     = aluout_q;
    mdr_d        = mdr_q;
    result_d     = result_q;
    zero_d       = zero_q;
    neg_d        = neg_q;
    ovf_d        = ovf_q;
    instr_done_d = 1'b0;
    halted_d     = halted_q;
    regs_d       = regs_q;
    case (state_q)
      ST_FETCH: begin
        if (updPc && imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        a_d = rs_val;
        b_d = rt_val;
        if (ir_q[OPC_LSB +: 6] == OP_HALT) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        aluout_d = alu_result;
        zero_d   = alu_zero;
        neg_d    = alu_neg;
        ovf_d    = alu_ovf;
        if (rdMem || wrMem) begin
          state_d = ST_MEM;
        end else begin
          state_d      = ST_WB;
          instr_done_d = 1'b1;
        end
      end
      ST_MEM: begin
        if (dmem_ack) begin
          if (rdMem) mdr_d = dmem_rdata;
          state_d      = ST_WB;
          instr_done_d = 1'b1;
        end
      end
      ST_WB: begin
        result_d = wb_data;
        if (wr_reg && reg_impl(dest_idx)) regs_d[dest_idx] = wb_data;
        pc_d    = taken ? aluout_q : pc_plus1;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State and latch registers; reset clears everything and aborts any transaction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= '0;
      ir_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      aluout_q     <= '0;
      mdr_q        <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      neg_q        <= 1'b0;
      ovf_q        <= 1'b0;
      instr_done_q <= 1'b0;
      halted_q     <= 1'b0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      a_q          <= a_d;
      b_q          <= b_d;
      aluout_q     <= aluout_d;
      mdr_q        <= mdr_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      neg_q        <= neg_d;
      ovf_q        <= ovf_d;
      instr_done_q <= instr_done_d;
      halted_q     <= halted_d;
      regs_q       <= regs_d;
    end
  end

  // Requests decode straight from the state register so reset drops them immediately
  assign imem_req   = (state_q == ST_FETCH) && updPc && !reset;
  assign imem_addr  = pc_q[ADDR_W-1:0];
  assign dmem_req   = (state_q == ST_MEM);
  assign dmem_we    = (state_q == ST_MEM) && wrMem;
  assign dmem_addr  = aluout_q[ADDR_W-1:0];
  assign dmem_wdata = b_q;

  assign opcode        = ir_q[OPC_LSB +: 6];
  assign funct         = ir_q[5:0];
  assign ins           = ir_q;
  assign result_out    = result_q;
  assign rsOut_out     = a_q;
  assign resultRegOut  = dbg_val;
  assign zero          = zero_q;
  assign negative      = neg_q;
  assign overflow_flag = ovf_q;
  assign instr_done    = instr_done_q;
  assign halted        = halted_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: a short program of ALU, memory and
// branch instructions fed through the req/ack ports, then reset-in-MEM, fetch
// stall and HALT. Expected values are hand-computed constants.
module tb_multicycle_datapath;
  import mc_pkg::*;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam logic [5:0] OP_STD = 6'h01;

  // Clock and reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          updPc, reg_dst, wr_reg, alu_src, immSel, rdMem, wrMem, mToReg;
  logic [3:0]    alu_control, resultRegInp;
  logic [2:0]    brOp;
  logic          imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic [AW-1:0] imem_addr, dmem_addr;
  logic [31:0]   imem_rdata, ins;
  logic [DW-1:0] dmem_wdata, dmem_rdata, result_out, rsOut_out, resultRegOut;
  logic [5:0]    opcode, funct;
  logic          zero, negative, overflow_flag, instr_done, halted;
  mc_state_e     state_dbg;

  multicycle_datapath #(.DATA_W(DW), .ADDR_W(AW), .NREGS(16)) dut (
    .clk(clk), .reset(reset), .updPc(updPc), .reg_dst(reg_dst), .wr_reg(wr_reg),
    .alu_control(alu_control), .alu_src(alu_src), .immSel(immSel), .rdMem(rdMem),
    .wrMem(wrMem), .mToReg(mToReg), .brOp(brOp), .resultRegInp(resultRegInp),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .opcode(opcode), .funct(funct), .ins(ins),
    .result_out(result_out), .rsOut_out(rsOut_out), .resultRegOut(resultRegOut),
    .zero(zero), .negative(negative), .overflow_flag(overflow_flag),
    .instr_done(instr_done), .halted(halted), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] dmem_model [256];

  typedef struct packed {
    logic       reg_dst;
    logic       wr_reg;
    logic [3:0] alu;
    logic       alu_src;
    logic       imm_sel;
    logic       rd_mem;
    logic       wr_mem;
    logic       m_to_reg;
    logic [2:0] br;
  } ctl_t;

  // Comparison point
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [3:0] rs,
                                        input logic [3:0] rt, input logic [3:0] rd,
                                        input logic [13:0] imm);
    return {op, rs, rt, rd, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [3:0] rs, input logic [21:0] off);
    return {OP_STD, rs, off};
  endfunction

  function automatic ctl_t ctl_i(input logic [3:0] op);
    ctl_t c = '0;
    c.wr_reg = 1'b1;
    c.alu    = op;
    return c;
  endfunction

  function automatic ctl_t ctl_r(input logic [3:0] op);
    ctl_t c = '0;
    c.reg_dst = 1'b1;
    c.wr_reg  = 1'b1;
    c.alu_src = 1'b1;
    c.alu     = op;
    return c;
  endfunction

  function automatic ctl_t ctl_br(input logic [2:0] br);
    ctl_t c = '0;
    c.alu     = ALU_ADD;
    c.imm_sel = 1'b1;
    c.br      = br;
    return c;
  endfunction

  function automatic ctl_t ctl_st();
    ctl_t c = '0;
    c.wr_mem = 1'b1;
    return c;
  endfunction

  function automatic ctl_t ctl_ld();
    ctl_t c = '0;
    c.rd_mem   = 1'b1;
    c.m_to_reg = 1'b1;
    c.wr_reg   = 1'b1;
    return c;
  endfunction

  // Driver: wait for the fetch request, apply controls, return the instruction with a same-cycle ack
  task automatic fetch_only(input string tag, input logic [31:0] ir, input ctl_t c);
    int guard = 0;
    while (imem_req !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_fetch_req"}, 64'(imem_req), 64'd1);
    {reg_dst, wr_reg, alu_control, alu_src, immSel, rdMem, wrMem, mToReg, brOp} = c;
    imem_rdata = ir;
    imem_ack   = 1'b1;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  // Driver: run one instruction to its WB cycle; data acks arrive ack_delay cycles after the request
  task automatic run_instr(input string tag, input logic [31:0] ir, input ctl_t c,
                           input int ack_delay, output int cycles);
    logic [AW-1:0] a0;
    logic [DW-1:0] w0;
    fetch_only(tag, ir, c);
    cycles = 2;
    while (instr_done !== 1'b1 && cycles < 30) begin
      if (dmem_req === 1'b1) begin
        a0 = dmem_addr;
        w0 = dmem_wdata;
        for (int k = 0; k < ack_delay; k++) begin
          @(negedge clk);
          cycles++;
          check({tag, "_req_held"}, 64'(dmem_req), 64'd1);
          check({tag, "_addr_stable"}, 64'(dmem_addr), 64'(a0));
          check({tag, "_wdata_stable"}, 64'(dmem_wdata), 64'(w0));
        end
        dmem_ack = 1'b1;
        if (dmem_we === 1'b1) dmem_model[dmem_addr[7:0]] = dmem_wdata;
        else                  dmem_rdata = dmem_model[dmem_addr[7:0]];
        @(negedge clk);
        cycles++;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'hBAD0_BAD0;
      end else begin
        @(negedge clk);
        cycles++;
      end
    end
    check({tag, "_instr_done"}, 64'(instr_done), 64'd1);
  endtask

  task automatic check_reg(input string tag, input logic [3:0] r, input logic [DW-1:0] exp);
    resultRegInp = r;
    #1;
    check(tag, 64'(resultRegOut), 64'(exp));
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 256; i++) dmem_model[i] = '0;
    reset = 1'b1; updPc = 1'b0;
    {reg_dst, wr_reg, alu_control, alu_src, immSel, rdMem, wrMem, mToReg, brOp} = '0;
    resultRegInp = '0; imem_rdata = '0; imem_ack = 1'b0; dmem_rdata = '0; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", 64'(state_dbg), 64'(ST_FETCH));
    check("rst_pc", 64'(imem_addr), 64'd0);
    check("rst_result", 64'(result_out), 64'd0);
    check("rst_reqs", 64'({imem_req, dmem_req}), 64'd0);
    check("rst_flags", 64'({zero, negative, overflow_flag, halted, instr_done}), 64'd0);
    reset = 1'b0;
    updPc = 1'b1;

    run_instr("addi_r1", enc_i(OP_STD, 4'd0, 4'd1, 4'd0, 14'd5), ctl_i(ALU_ADD), 0, cyc);
    run_instr("addi_r2", enc_i(OP_STD, 4'd0, 4'd2, 4'd0, 14'd7), ctl_i(ALU_ADD), 0, cyc);
    run_instr("add_r3", enc_i(OP_STD, 4'd1, 4'd2, 4'd3, 14'd0), ctl_r(ALU_ADD), 0, cyc);
    check("add_cpi", 64'(cyc), 64'd4);
    check("add_opcode", 64'(opcode), 64'(OP_STD));
    @(negedge clk);
    check("add_done_pulse", 64'(instr_done), 64'd0);
    check("add_result_out", 64'(result_out), 64'd12);
    check("add_pc", 64'(imem_addr), 64'd3);
    check_reg("add_r3_val", 4'd3, 32'd12);

    run_instr("store", enc_i(OP_STD, 4'd0, 4'd3, 4'd0, 14'd8), ctl_st(), 3, cyc);
    check("store_cycles", 64'(cyc), 64'd8);
    check("store_mem8", 64'(dmem_model[8]), 64'd12);
    @(negedge clk);
    check("store_result_out", 64'(result_out), 64'd8);
    run_instr("load", enc_i(OP_STD, 4'd0, 4'd4, 4'd0, 14'd8), ctl_ld(), 3, cyc);
    check("load_cycles", 64'(cyc), 64'd8);
    @(negedge clk);
    check_reg("load_r4", 4'd4, 32'd12);
    check("load_result_out", 64'(result_out), 64'd12);

    run_instr("addi_m1", enc_i(OP_STD, 4'd0, 4'd5, 4'd0, 14'h3FFF), ctl_i(ALU_ADD), 0, cyc);
    check("addi_m1_neg", 64'(negative), 64'd1);
    run_instr("srl", enc_i(OP_STD, 4'd5, 4'd5, 4'd0, 14'd1), ctl_i(ALU_SRL), 0, cyc);
    @(negedge clk);
    check_reg("srl_r5", 4'd5, 32'h7FFF_FFFF);
    run_instr("add_ovf", enc_i(OP_STD, 4'd5, 4'd6, 4'd0, 14'd1), ctl_i(ALU_ADD), 0, cyc);
    check("add_ovf_flags", 64'({zero, negative, overflow_flag}), 64'b011);
    run_instr("sub_zero", enc_i(OP_STD, 4'd1, 4'd7, 4'd0, 14'd5), ctl_i(ALU_SUB), 0, cyc);
    check("sub_zero_flags", 64'({zero, negative, overflow_flag}), 64'b100);
    run_instr("slt", enc_i(OP_STD, 4'd6, 4'd1, 4'd8, 14'd0), ctl_r(ALU_SLT), 0, cyc);
    @(negedge clk);
    check_reg("add_ovf_r6", 4'd6, 32'h8000_0000);
    check_reg("slt_r8", 4'd8, 32'd1);
    check("pc_before_br", 64'(imem_addr), 64'd10);

    run_instr("beqz_taken", enc_j(4'd0, 22'h3FFFFD), ctl_br(BR_A_ZERO), 0, cyc);
    check("beqz_a", 64'(rsOut_out), 64'd0);
    @(negedge clk);
    check("beqz_taken_pc", 64'(imem_addr), 64'd8);
    run_instr("br_always", enc_j(4'd0, 22'd1), ctl_br(BR_ALWAYS), 0, cyc);
    @(negedge clk);
    check("br_always_pc", 64'(imem_addr), 64'd10);
    run_instr("beqz_not", enc_j(4'd8, 22'h3FFFFD), ctl_br(BR_A_ZERO), 0, cyc);
    check("beqz_not_a", 64'(rsOut_out), 64'd1);
    @(negedge clk);
    check("beqz_not_pc", 64'(imem_addr), 64'd11);
    run_instr("addi_r9", enc_i(OP_STD, 4'd0, 4'd9, 4'd0, 14'h20), ctl_i(ALU_ADD), 0, cyc);
    run_instr("jreg", enc_j(4'd9, 22'd4), ctl_br(BR_JREG), 0, cyc);
    @(negedge clk);
    check("jreg_pc", 64'(imem_addr), 64'h24);
    run_instr("sra", enc_i(OP_STD, 4'd6, 4'd10, 4'd0, 14'd4), ctl_i(ALU_SRA), 0, cyc);
    @(negedge clk);
    check_reg("sra_r10", 4'd10, 32'hF800_0000);
    check("sra_pc", 64'(imem_addr), 64'h25);

    // Reset while a store waits in MEM
    fetch_only("st_abort", enc_i(OP_STD, 4'd0, 4'd3, 4'd0, 14'd16), ctl_st());
    repeat (2) @(negedge clk);
    check("st_abort_in_mem", 64'(dmem_req), 64'd1);
    #2;
    reset = 1'b1;
    updPc = 1'b0;
    #1;
    check("st_abort_req_drop", 64'(dmem_req), 64'd0);
    check("st_abort_state", 64'(state_dbg), 64'(ST_FETCH));
    check("st_abort_pc", 64'(imem_addr), 64'd0);
    check_reg("st_abort_r3", 4'd3, 32'd0);
    check("st_abort_a", 64'(rsOut_out), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Fetch stalls while updPc is low
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_req", 64'(imem_req), 64'd0);
    end
    check("stall_state", 64'(state_dbg), 64'(ST_FETCH));
    check("mem16_untouched", 64'(dmem_model[16]), 64'd0);
    updPc = 1'b1;

    // HALT is sticky and suppresses further fetches
    fetch_only("halt", enc_i(OP_HALT, 4'd0, 4'd0, 4'd0, 14'd0), ctl_i(ALU_ADD));
    @(negedge clk);
    check("halt_flag", 64'(halted), 64'd1);
    check("halt_opcode", 64'(opcode), 64'(OP_HALT));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("halt_no_req", 64'({imem_req, instr_done}), 64'd0);
    end
    check("halt_state", 64'(state_dbg), 64'(ST_HALT));
    check("halt_sticky", 64'(halted), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
